sm_cpu_mc: RTL and testbench



---
 rtl/sm_cpu_mc_if.sv | 10 +
 rtl/sm_cpu_mc.sv | 188 ++++++++++++++++++
 tb/tb_sm_cpu_mc.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_cpu_mc_if.sv
// rtl/sm_cpu_mc_if.sv - instruction fetch req/valid bus between the core and instruction memory
interface sm_cpu_mc_if;
  logic [31:0] imAddr;
  logic        imReq;
  logic        imValid;
  logic [31:0] imData;

  modport master (output imAddr, output imReq, input imValid, input imData);
  modport slave  (input imAddr, input imReq, output imValid, output imData);
endinterface

// File: rtl/sm_cpu_mc.sv
// rtl/sm_cpu_mc.sv - multicycle schoolMIPS core; define SM_CPU_MC_ILLEGAL_TRAP_EN to halt on undefined opcodes
module sm_cpu_mc #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          MUL_BITS = 1,
  parameter int          EXT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EXT_W-1:0] extraInput,
  input  logic [4:0]       regAddr,
  output logic [31:0]      regData,
  sm_cpu_mc_if.master      im,
  output logic             instrDone,
  output logic             halted
);
  localparam int          MUL_STEPS = 32 / MUL_BITS;
  localparam logic [5:0]  MUL_LAST  = 6'(MUL_STEPS - 1);
  localparam logic [31:0] EXT_MASK  = (32'h1 << EXT_W) - 32'h1;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MUL, S_HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rf [0:31];
  logic [31:0] mulA, mulB, acc, accNext;
  logic [5:0]  mulCnt;
  logic        mulLast;

  logic [5:0]  op, funct;
  logic [4:0]  rsA, rtA, rdA, shamt;
  logic [15:0] imm16;
  logic [31:0] signImm, rsVal, rtVal, pcPlus1, extZ, lwData;
  logic        parity;

  logic        exWe, legal, isMul;
  logic [4:0]  exAddr;
  logic [31:0] exData, exPc;
  logic        rfWe;
  logic [4:0]  rfWAddr;
  logic [31:0] rfWData;

  assign op      = instr[31:26];
  assign rsA     = instr[25:21];
  assign rtA     = instr[20:16];
  assign rdA     = instr[15:11];
  assign shamt   = instr[10:6];
  assign funct   = instr[5:0];
  assign imm16   = instr[15:0];
  assign signImm = {{16{imm16[15]}}, imm16};
  assign rsVal   = (rsA == 5'd0) ? 32'd0 : rf[rsA];
  assign rtVal   = (rtA == 5'd0) ? 32'd0 : rf[rtA];
  assign pcPlus1 = pc + 32'd1;

  // LW with a nonzero offset fills the bits above extraInput with its parity, top bit clear
  assign extZ    = 32'(extraInput);
  assign parity  = ^extraInput;
  assign lwData  = (imm16 == 16'd0 || !parity) ? extZ : ((32'h7FFF_FFFF & ~EXT_MASK) | extZ);

  // Request is dropped combinationally while rst is high so memory never sees a fetch during reset
  assign im.imReq  = (state == S_FETCH) && !rst;
  assign im.imAddr = pc;
  assign regData   = (regAddr == 5'd0) ? pc : rf[regAddr];

  // Decode and ALU for the latched instruction; only consumed in S_EXEC
  always_comb begin
    exWe   = 1'b0;
    exAddr = rtA;
    exData = 32'd0;
    exPc   = pcPlus1;
    legal  = 1'b1;
    isMul  = 1'b0;
    case (op)
      6'h00: begin
        exAddr = rdA;
        exWe   = 1'b1;
        case (funct)
          6'h21:   exData = rsVal + rtVal;
          6'h25:   exData = rsVal | rtVal;
          6'h02:   exData = rtVal >> shamt;
          6'h2B:   exData = {31'd0, rsVal < rtVal};
          6'h23:   exData = rsVal - rtVal;
          6'h24:   exData = rsVal & rtVal;
          default: begin exWe = 1'b0; legal = 1'b0; end
        endcase
      end
      6'h1C: begin
        if (funct == 6'h02) isMul = 1'b1;
        else                legal = 1'b0;
      end
      6'h09: begin exWe = 1'b1; exData = rsVal + signImm; end
      6'h0D: begin exWe = 1'b1; exData = rsVal | signImm; end
      6'h0F: begin exWe = 1'b1; exData = {imm16, 16'h0000}; end
      6'h04: if (rsVal == rtVal) exPc = pcPlus1 + signImm;
      6'h05: if (rsVal != rtVal) exPc = pcPlus1 + signImm;
      6'h02: exPc = {pcPlus1[31:26], instr[25:0]};
      6'h23: begin exWe = 1'b1; exData = lwData; end
      default: legal = 1'b0;
    endcase
  end

  // One shift-and-add step: retire MUL_BITS multiplier bits into the accumulator
  always_comb begin
    accNext = acc;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mulB[i]) accNext = accNext + (mulA << i);
    end
  end

  assign mulLast = (mulCnt == MUL_LAST);

  // Single write port: ALU result from S_EXEC or product on the last S_MUL cycle; reset suppresses it
  always_comb begin
    rfWe    = 1'b0;
    rfWAddr = exAddr;
    rfWData = exData;
    if (state == S_EXEC) begin
      rfWe = exWe;
    end else if (state == S_MUL && mulLast) begin
      rfWe    = 1'b1;
      rfWAddr = rdA;
      rfWData = accNext;
    end
    if (rst || rfWAddr == 5'd0) rfWe = 1'b0;
  end

  // Register file, intentionally not reset
  always_ff @(posedge clk) begin
    if (rfWe) rf[rfWAddr] <= rfWData;
  end

  // Main control FSM with registered pc/instrDone/halted
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      instrDone <= 1'b0;
`ifdef SM_CPU_MC_ILLEGAL_TRAP_EN
      halted    <= 1'b0;
`endif
    end else begin
      instrDone <= 1'b0;
      case (state)
        S_FETCH: begin
          if (im.imValid) begin
            instr <= im.imData;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef SM_CPU_MC_ILLEGAL_TRAP_EN
          if (!legal) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else
`endif
          if (isMul) begin
            mulA   <= rsVal;
            mulB   <= rtVal;
            acc    <= 32'd0;
            mulCnt <= 6'd0;
            state  <= S_MUL;
          end else begin
            pc        <= exPc;
            instrDone <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_MUL: begin
          acc    <= accNext;
          mulA   <= mulA << MUL_BITS;
          mulB   <= mulB >> MUL_BITS;
          mulCnt <= mulCnt + 6'd1;
          if (mulLast) begin
            pc        <= pcPlus1;
            instrDone <= 1'b1;
            state     <= S_FETCH;
          end
        end
        default: state <= state;
      endcase
    end
  end

`ifndef SM_CPU_MC_ILLEGAL_TRAP_EN
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_sm_cpu_mc.sv
// tb/tb_sm_cpu_mc.sv - directed self-checking bench for sm_cpu_mc (SM_CPU_MC_ILLEGAL_TRAP_EN optional)
module tb_sm_cpu_mc;
  logic        clk = 1'b0;
  logic        rst1 = 1'b1, rst4 = 1'b1;
  logic [7:0]  ext1 = 8'h68, ext4 = 8'h00;
  logic [4:0]  ra1 = 5'd0, ra4 = 5'd0;
  logic [31:0] rd1, rd4;
  logic        done1, done4, halt1, halt4;
  logic        forceValid1 = 1'b1;
  int          waitCycles1 = 0;
  int          reqAge1 = 0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          mulAcc1 = -1, mulAcc4a = -1, mulAcc4b = -1;
  logic        prevReq1 = 1'b0, prevAcc1 = 1'b0;
  logic [31:0] prevAddr1 = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rt(input int rs, input int rtr, input int rd, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rtr), 5'(rd), 5'(sh), fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input int rs, input int rtr, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rtr), imm};
  endfunction
  function automatic logic [31:0] mul(input int rs, input int rtr, input int rd);
    return {6'h1C, 5'(rs), 5'(rtr), 5'(rd), 5'd0, 6'h02};
  endfunction

  function automatic logic [31:0] rom1(input logic [31:0] a);
    case (a)
      32'h10: return it(6'h09, 0, 1, 16'd5);
      32'h11: return rt(1, 1, 2, 0, 6'h21);
      32'h12: return rt(0, 0, 2, 0, 6'h21);
      32'h13: return it(6'h09, 0, 1, 16'hFFFF);
      32'h14: return it(6'h09, 0, 2, 16'd3);
      32'h15: return mul(1, 2, 3);
      32'h16: return rt(2, 1, 4, 0, 6'h23);
      32'h17: return rt(2, 1, 5, 0, 6'h2B);
      32'h18: return rt(1, 2, 6, 0, 6'h2B);
      32'h19: return rt(0, 1, 7, 4, 6'h02);
      32'h1A: return it(6'h0F, 0, 8, 16'h1234);
      32'h1B: return it(6'h0D, 8, 8, 16'h5678);
      32'h1C: return rt(8, 7, 9, 0, 6'h24);
      32'h1D: return rt(9, 2, 10, 0, 6'h25);
      32'h1E: return it(6'h23, 0, 11, 16'd1);
      32'h1F: return it(6'h23, 0, 12, 16'd0);
      32'h20: return it(6'h09, 0, 0, 16'd7);
      32'h21: return it(6'h0D, 0, 13, 16'd1);
      32'h22: return it(6'h05, 0, 0, 16'd4);
      32'h23: return it(6'h04, 1, 1, 16'd2);
      32'h24: return it(6'h09, 0, 14, 16'd1);
      32'h25: return it(6'h09, 0, 14, 16'd1);
      32'h26: return 32'hFC00_0000;
      default: return it(6'h04, 0, 0, 16'hFFFF);
    endcase
  endfunction

  function automatic logic [31:0] rom4(input logic [31:0] a);
    case (a)
      32'h0400_0000: return {6'h02, 26'h3FF_FFFF};
      32'h07FF_FFFF: return it(6'h09, 0, 1, 16'hFFFF);
      32'h0800_0000: return it(6'h09, 0, 2, 16'd3);
      32'h0800_0001: return it(6'h09, 0, 4, 16'h0055);
      32'h0800_0002: return mul(1, 2, 3);
      32'h0800_0003: return mul(1, 1, 4);
      default:       return it(6'h04, 0, 0, 16'hFFFF);
    endcase
  endfunction

  sm_cpu_mc_if bus1();
  sm_cpu_mc_if bus4();

  assign bus1.imValid = forceValid1 | (bus1.imReq & (reqAge1 >= waitCycles1));
  assign bus1.imData  = rom1(bus1.imAddr);
  assign bus4.imValid = bus4.imReq;
  assign bus4.imData  = rom4(bus4.imAddr);

  always @(posedge clk) reqAge1 <= (bus1.imReq && !bus1.imValid) ? reqAge1 + 1 : 0;

  sm_cpu_mc #(.RESET_PC(32'h10), .MUL_BITS(1), .EXT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .extraInput(ext1), .regAddr(ra1), .regData(rd1),
    .im(bus1), .instrDone(done1), .halted(halt1)
  );

  sm_cpu_mc #(.RESET_PC(32'h0400_0000), .MUL_BITS(4), .EXT_W(8)) dut4 (
    .clk(clk), .rst(rst4), .extraInput(ext4), .regAddr(ra4), .regData(rd4),
    .im(bus4), .instrDone(done4), .halted(halt4)
  );

  // While a fetch is pending, the request and address must not move
  always @(negedge clk) begin
    if (prevReq1 && !prevAcc1 && !rst1) begin
      checks++;
      assert (bus1.imReq === 1'b1 && bus1.imAddr === prevAddr1)
      else begin
        errors++;
        $error("FAIL fetchHold: req=%b addr=%h expected req=1 addr=%h", bus1.imReq, bus1.imAddr, prevAddr1);
      end
    end
    prevReq1  <= bus1.imReq;
    prevAcc1  <= bus1.imReq && bus1.imValid;
    prevAddr1 <= bus1.imAddr;
  end

  // Cycle index of the edge that accepts each MUL fetch
  always @(negedge clk) begin
    if (bus1.imReq && bus1.imValid && bus1.imAddr == 32'h15) mulAcc1 <= cyc + 1;
    if (bus4.imReq && bus4.imValid && bus4.imAddr == 32'h0800_0002) mulAcc4a <= cyc + 1;
    if (bus4.imReq && bus4.imValid && bus4.imAddr == 32'h0800_0003) mulAcc4b <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic waitDone(input int which, output int at);
    int n = 0;
    @(negedge clk);
    while (((which == 1) ? done1 : done4) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100)
    else begin
      errors++;
      $error("FAIL doneTimeout%0d: waited %0d cycles, limit 100", which, n);
    end
    at = cyc;
  endtask

  task automatic rd1chk(input string tag, input int r, input logic [31:0] exp);
    ra1 = 5'(r);
    #1;
    chk(tag, rd1, exp);
  endtask

  task automatic rd4chk(input string tag, input int r, input logic [31:0] exp);
    ra4 = 5'(r);
    #1;
    chk(tag, rd4, exp);
  endtask

  int          tReg[12] = '{4, 5, 6, 7, 8, 8, 9, 10, 11, 12, 0, 13};
  logic [31:0] tVal[12] = '{32'h4, 32'h1, 32'h0, 32'h0FFF_FFFF, 32'h1234_0000, 32'h1234_5678,
                            32'h0234_5678, 32'h0234_567B, 32'h7FFF_FF68, 32'h0000_0068,
                            32'h0000_0021, 32'h0000_0001};

  initial begin
    int t0, t1, tm, n, pulses;

    // Reset with imValid held high: no request, no retire
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstReq", {31'd0, bus1.imReq}, 32'd0);
    chk("rstDone", {31'd0, done1}, 32'd0);
    chk("rstHalt", {31'd0, halt1}, 32'd0);
    rd1chk("rstPc", 0, 32'h10);
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk);
    chk("firstAddr", bus1.imAddr, 32'h10);
    chk("firstReq", {31'd0, bus1.imReq}, 32'd1);

    // Zero-wait memory: ADDIU then ADDU, one retire every 2 cycles
    waitDone(1, t0);
    rd1chk("addiuR1", 1, 32'd5);
    waitDone(1, t1);
    chk("rate2", 32'(t1 - t0), 32'd2);
    rd1chk("adduR2", 2, 32'd10);
    waitDone(1, t0);
    rd1chk("adduZero", 2, 32'd0);

    // Same program with 3 wait states per fetch
    @(posedge clk); #1;
    rst1 = 1'b1; forceValid1 = 1'b0; waitCycles1 = 3;
    @(posedge clk); #1 rst1 = 1'b0;
    waitDone(1, t0);
    waitDone(1, t1);
    chk("rate5", 32'(t1 - t0), 32'd5);
    rd1chk("slowR2", 2, 32'd10);
    @(posedge clk); #1 waitCycles1 = 0;

    waitDone(1, t0);
    rd1chk("clrR2", 2, 32'd0);
    waitDone(1, t0);
    rd1chk("negImm", 1, 32'hFFFF_FFFF);
    waitDone(1, t0);
    rd1chk("r2is3", 2, 32'd3);
    waitDone(1, tm);
    chk("mulLat1", 32'(tm - mulAcc1), 32'd33);
    rd1chk("mulR3", 3, 32'hFFFF_FFFD);

    for (int i = 0; i < 12; i++) begin
      waitDone(1, t0);
      rd1chk($sformatf("alu%0d", i), tReg[i], tVal[i]);
    end

    waitDone(1, t0);
    chk("bneNotTaken", bus1.imAddr, 32'h23);
    waitDone(1, t0);
    chk("beqTaken", bus1.imAddr, 32'h26);

`ifdef SM_CPU_MC_ILLEGAL_TRAP_EN
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    chk("haltNoDone", 32'(pulses), 32'd0);
    chk("haltFlag", {31'd0, halt1}, 32'd1);
    chk("haltNoReq", {31'd0, bus1.imReq}, 32'd0);
    rd1chk("haltPc", 0, 32'h26);
    @(posedge clk); #1 rst1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("haltCleared", {31'd0, halt1}, 32'd0);
    rd1chk("haltRstPc", 0, 32'h10);
`else
    waitDone(1, t0);
    chk("undefNop", bus1.imAddr, 32'h27);
    chk("noHalt", {31'd0, halt1}, 32'd0);
    waitDone(1, t0);
    chk("beqSelf", bus1.imAddr, 32'h27);
    @(posedge clk); #1 rst1 = 1'b1;
`endif

    // MUL_BITS=4 core: J from 0x0400_0000, MUL latency, reset abort
    @(posedge clk); #1 rst4 = 1'b0;
    waitDone(4, t0);
    chk("jTarget", bus4.imAddr, 32'h07FF_FFFF);
    waitDone(4, t0);
    rd4chk("d4r1", 1, 32'hFFFF_FFFF);
    waitDone(4, t0);
    waitDone(4, t0);
    rd4chk("d4r4", 4, 32'h55);
    waitDone(4, tm);
    chk("mulLat4", 32'(tm - mulAcc4a), 32'd9);
    rd4chk("mul4R3", 3, 32'hFFFF_FFFD);

    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(mulAcc4b >= 0 && cyc == mulAcc4b + 5) && n < 50);
    checks++;
    assert (n < 50)
    else begin
      errors++;
      $error("FAIL abortTimeout: waited %0d cycles, limit 50", n);
    end
    rst4 = 1'b1;
    @(posedge clk); #1 rst4 = 1'b0;
    @(negedge clk);
    chk("abortDone", {31'd0, done4}, 32'd0);
    rd4chk("abortPc", 0, 32'h0400_0000);
    repeat (4) @(negedge clk);
    rd4chk("abortNoWrite", 4, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
